// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, state encoding and PC helper for the fetch stage.
// Revision: 1.0
`default_nettype none

package inst_fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_CTRL = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_perf_ctr.sv
// fetch_perf_ctr: saturating event counter, only built with INST_FETCH_PERF_EN.
// Revision: 1.0
`default_nettype none

`ifdef INST_FETCH_PERF_EN
module fetch_perf_ctr #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule
`endif

`default_nettype wire

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and single-outstanding instruction fetch feeding decode.
// Optional perf counters via INST_FETCH_PERF_EN. Revision: 1.0
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic        inst_valid
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic [31:0]  r_pend_inst;
  logic [31:0]  r_inst;
  logic [31:0]  r_pc_out;
  logic         r_drop;
  logic         r_inst_valid;

  logic w_req_fire;
  logic w_outstanding;
  logic w_resp_ok;

  assign imem_req_valid = (r_state == S_REQ) & ~r_drop & ~stall & ~hold;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;
  // A request accepted this very cycle is outstanding too, even if a redirect
  // moves the PC away at the same edge.
  assign w_outstanding  = w_req_fire | ((r_state == S_WAIT) & ~imem_resp_valid);
  assign w_resp_ok      = (r_state == S_WAIT) & imem_resp_valid & ~r_drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_pend_inst  <= NOP_INST;
      r_drop       <= 1'b0;
      r_inst       <= NOP_INST;
      r_pc_out     <= RESET_PC;
      r_inst_valid <= 1'b0;
    end else begin
      r_drop <= ((redirect_valid | stall) & w_outstanding) | (r_drop & ~imem_resp_valid);
      if (!hold) begin
        r_inst       <= NOP_INST;
        r_inst_valid <= 1'b0;
      end
      if (redirect_valid) begin
        r_pc    <= redirect_pc & PC_ALIGN_MASK;
        r_state <= S_REQ;
      end else if (stall) begin
        r_state <= S_CTRL;
      end else begin
        case (r_state)
          S_REQ: begin
            if (w_req_fire) begin
              r_req_pc <= r_pc;
              r_state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (w_resp_ok) begin
              if (!hold) begin
                r_inst       <= imem_resp_data;
                r_pc_out     <= r_req_pc;
                r_inst_valid <= 1'b1;
                r_pc         <= pc_next(r_req_pc);
                r_state      <= S_REQ;
              end else begin
                r_pend_inst <= imem_resp_data;
                r_state     <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!hold) begin
              r_inst       <= r_pend_inst;
              r_pc_out     <= r_req_pc;
              r_inst_valid <= 1'b1;
              r_pc         <= pc_next(r_req_pc);
              r_state      <= S_REQ;
            end
          end
          S_CTRL: begin
            r_state <= S_CTRL;
          end
          default: begin
            r_state <= S_REQ;
          end
        endcase
      end
    end
  end

  assign inst       = r_inst;
  assign pc_out     = r_pc_out;
  assign inst_valid = r_inst_valid;

`ifdef INST_FETCH_PERF_EN
  fetch_perf_ctr #(.WIDTH(32)) u_perf_fetched (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (r_inst_valid),
    .o_count (perf_fetched)
  );

  fetch_perf_ctr #(.WIDTH(32)) u_perf_bubbles (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (~r_inst_valid & ~hold),
    .o_count (perf_bubbles)
  );
`endif

endmodule

`default_nettype wire
